// File: rtl/dreg_pkg.sv
// Shared types for the dreg_bank register bank: operating modes and readout FSM states.
package dreg_pkg;

    typedef enum logic [1:0] {
        MODE_TRACK    = 2'b00,
        MODE_SNAPSHOT = 2'b01,
        MODE_HOLD     = 2'b10,
        MODE_CLEAR    = 2'b11
    } mode_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

endpackage

// File: rtl/dreg_channel.sv
// One channel of dreg_bank: q register, change pulse, and optional even parity
// (DREG_BANK_PARITY_EN).
module dreg_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nq,
    output logic [WIDTH-1:0] q,
    output logic             changed
`ifdef DREG_BANK_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;

    assign nq     = load ? d : q_r;
    assign q_next = clear ? '0 : nq;
    assign q      = q_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= '0;
            changed <= 1'b0;
        end else begin
            q_r     <= q_next;
            changed <= (q_next != q_r);
        end
    end

`ifdef DREG_BANK_PARITY_EN
    logic par_r;

    // Parity is refreshed from the value being stored, so a corrupted q bit
    // is flagged exactly once before the stored parity re-aligns.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r      <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_r      <= ^q_next;
            parity_err <= ((^q_r) != par_r);
        end
    end
`endif

endmodule

// File: rtl/dreg_bank.sv
// Multi-channel D-register bank with mode select and atomic snapshot readout.
// Optional per-channel parity via DREG_BANK_PARITY_EN.
module dreg_bank
    import dreg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic                      capture,
    input  logic                      clr_overrun,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       changed,
    output logic [CHANNELS*WIDTH-1:0] snap_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun
`ifdef DREG_BANK_PARITY_EN
    ,
    output logic [CHANNELS-1:0]       parity_err
`endif
);

    mode_e                      m;
    logic                       load_ok;
    logic                       clear;
    logic                       cap_ok;
    logic [CHANNELS*WIDTH-1:0]  nq_all;
    state_e                     state, state_nx;
    logic                       snap_load;
    logic                       ovr_set;

    assign m       = mode_e'(mode);
    assign load_ok = (m == MODE_TRACK) || (m == MODE_SNAPSHOT);
    assign clear   = (m == MODE_CLEAR);
    assign cap_ok  = (m == MODE_SNAPSHOT) && capture;

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        dreg_channel #(.WIDTH(WIDTH)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .load       (en[i] && load_ok),
            .clear      (clear),
            .d          (d[i*WIDTH +: WIDTH]),
            .nq         (nq_all[i*WIDTH +: WIDTH]),
            .q          (q[i*WIDTH +: WIDTH]),
            .changed    (changed[i])
`ifdef DREG_BANK_PARITY_EN
            ,
            .parity_err (parity_err[i])
`endif
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        snap_load = 1'b0;
        ovr_set   = 1'b0;
        if (clear) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (cap_ok) begin
                        snap_load = 1'b1;
                        state_nx  = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (cap_ok) snap_load = 1'b1;
                        else        state_nx  = ST_EMPTY;
                    end else if (cap_ok) begin
                        ovr_set = 1'b1;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    assign out_valid = (state == ST_FULL);

    always_ff @(posedge clk) begin
        if (rst || clear)   snap_q <= '0;
        else if (snap_load) snap_q <= nq_all;
    end

    // A new overrun in the same cycle as a clear request takes priority.
    always_ff @(posedge clk) begin
        if (rst)                       overrun <= 1'b0;
        else if (ovr_set)              overrun <= 1'b1;
        else if (clr_overrun || clear) overrun <= 1'b0;
    end

`ifdef DREG_BANK_PARITY_EN
    logic [CHANNELS-1:0] snap_par;

    always_ff @(posedge clk) begin
        if (rst || clear) snap_par <= '0;
        else if (snap_load) begin
            for (int unsigned i = 0; i < CHANNELS; i++)
                snap_par[i] <= ^nq_all[i*WIDTH +: WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_dreg_bank.sv
// Scoreboard testbench for dreg_bank; parity checks run when DREG_BANK_PARITY_EN is defined.
module tb_dreg_bank;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int DW = W * CH;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [CH-1:0] en;
    logic [DW-1:0] d;
    logic          capture;
    logic          clr_overrun;
    logic [DW-1:0] q;
    logic [CH-1:0] changed;
    logic [DW-1:0] snap_q;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
`ifdef DREG_BANK_PARITY_EN
    logic [CH-1:0] parity_err;
`endif

    always #5 clk = ~clk;

    dreg_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .en          (en),
        .d           (d),
        .capture     (capture),
        .clr_overrun (clr_overrun),
        .q           (q),
        .changed     (changed),
        .snap_q      (snap_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun)
`ifdef DREG_BANK_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    typedef struct {
        logic [DW-1:0] q;
        logic [CH-1:0] chg;
        logic [DW-1:0] snap;
        logic          v;
        logic          o;
        logic [CH-1:0] perr;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_q    = '0;
    logic [DW-1:0] m_snap = '0;
    logic          m_v    = 1'b0;
    logic          m_o    = 1'b0;
    logic [CH-1:0] m_perr = '0;
    logic [CH-1:0] m_perr_next = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Spec-level model: advance one edge and queue the outputs it should produce.
    task automatic model_edge(input logic r, input logic [1:0] md, input logic [CH-1:0] e,
                              input logic [DW-1:0] dd, input logic cap, input logic rdy,
                              input logic clr);
        exp_t          x;
        logic [DW-1:0] nq;
        logic [CH-1:0] chg;
        logic          oset;
        oset = 1'b0;
        chg  = '0;
        for (int i = 0; i < CH; i++)
            nq[i*W +: W] = (e[i] && (md == 2'b00 || md == 2'b01)) ? dd[i*W +: W] : m_q[i*W +: W];
        if (r) begin
            m_q = '0; m_snap = '0; m_v = 1'b0; m_o = 1'b0; m_perr = '0;
        end else if (md == 2'b11) begin
            for (int i = 0; i < CH; i++) chg[i] = (m_q[i*W +: W] != '0);
            m_q = '0; m_snap = '0; m_v = 1'b0; m_o = 1'b0;
            m_perr = m_perr_next;
        end else begin
            for (int i = 0; i < CH; i++) chg[i] = (nq[i*W +: W] != m_q[i*W +: W]);
            if (!m_v) begin
                if (md == 2'b01 && cap) begin m_snap = nq; m_v = 1'b1; end
            end else if (rdy) begin
                if (md == 2'b01 && cap) m_snap = nq;
                else                    m_v = 1'b0;
            end else if (md == 2'b01 && cap) begin
                oset = 1'b1;
            end
            if (oset)     m_o = 1'b1;
            else if (clr) m_o = 1'b0;
            m_q = nq;
            m_perr = m_perr_next;
        end
        m_perr_next = '0;
        x.q = m_q; x.chg = r ? '0 : chg; x.snap = m_snap; x.v = m_v; x.o = m_o; x.perr = m_perr;
        sb.push_back(x);
    endtask

    task automatic step(input logic r, input logic [1:0] md, input logic [CH-1:0] e,
                        input logic [DW-1:0] dd, input logic cap, input logic rdy,
                        input logic clr);
        exp_t x;
        @(negedge clk);
        rst = r; mode = md; en = e; d = dd; capture = cap; out_ready = rdy; clr_overrun = clr;
        model_edge(r, md, e, dd, cap, rdy, clr);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_val("q",         64'(q),         64'(x.q));
        check_val("changed",   64'(changed),   64'(x.chg));
        check_val("snap_q",    64'(snap_q),    64'(x.snap));
        check_val("out_valid", 64'(out_valid), 64'(x.v));
        check_val("overrun",   64'(overrun),   64'(x.o));
`ifdef DREG_BANK_PARITY_EN
        check_val("parity_err", 64'(parity_err), 64'(x.perr));
`endif
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; en = '0; d = '0; capture = 1'b0;
        out_ready = 1'b0; clr_overrun = 1'b0;

        // Reset / TRACK
        step(1, 2'b00, 4'b0000, 32'h0,        0, 0, 0);
        step(1, 2'b00, 4'b0000, 32'h0,        0, 0, 0);
        step(0, 2'b00, 4'b0101, 32'h00330011, 0, 0, 0);
        step(0, 2'b00, 4'b0000, 32'h00330011, 0, 0, 0);

        // HOLD: q frozen, capture ignored
        step(0, 2'b00, 4'b1111, 32'hAAAAAAAA, 0, 0, 0);
        step(0, 2'b10, 4'b1111, 32'h55555555, 1, 0, 0);
        step(0, 2'b10, 4'b1111, 32'h55555555, 1, 1, 0);

        // Snapshot handshake with stall
        step(0, 2'b01, 4'b0010, 32'h00007E00, 1, 0, 0);
        for (int k = 0; k < 3; k++)
            step(0, 2'b10, 4'b0000, 32'h12345678, 0, 0, 0);
        step(0, 2'b10, 4'b0000, 32'h0,        0, 1, 0);

        // Overrun while stalled, persistence, clear, set-beats-clear
        step(0, 2'b01, 4'b0100, 32'h00C30000, 1, 0, 0);
        step(0, 2'b01, 4'b1111, 32'h01010101, 1, 0, 0);
        step(0, 2'b10, 4'b0000, 32'h0,        0, 1, 0);
        step(0, 2'b10, 4'b0000, 32'h0,        0, 0, 0);
        step(0, 2'b10, 4'b0000, 32'h0,        0, 0, 1);
        step(0, 2'b01, 4'b0001, 32'h000000F0, 1, 0, 0);
        step(0, 2'b01, 4'b0001, 32'h000000F1, 1, 0, 1);

        // Back-to-back snapshot, then CLEAR
        step(0, 2'b01, 4'b1000, 32'h9C000000, 1, 1, 0);
        step(0, 2'b01, 4'b0011, 32'h00002233, 1, 1, 0);
        step(0, 2'b11, 4'b1111, 32'hFFFFFFFF, 1, 0, 0);
        step(0, 2'b00, 4'b0000, 32'h0,        0, 0, 0);

        // Random traffic
        for (int k = 0; k < 40; k++)
            step(0, 2'($urandom_range(0, 3)), 4'($urandom), $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

        // Reset during FULL discards the snapshot
        step(0, 2'b01, 4'b1111, 32'h0F1E2D3C, 1, 0, 0);
        step(1, 2'b01, 4'b1111, 32'h11111111, 1, 0, 0);
        step(0, 2'b00, 4'b0000, 32'h0,        0, 0, 0);

`ifdef DREG_BANK_PARITY_EN
        step(0, 2'b00, 4'b1111, 32'h44332211, 0, 0, 0);
        dut.gen_ch[1].u_ch.q_r[0] = ~dut.gen_ch[1].u_ch.q_r[0];
        m_q[8] = ~m_q[8];
        m_perr_next = 4'b0010;
        step(0, 2'b10, 4'b0000, 32'h0,        0, 0, 0);
        step(0, 2'b10, 4'b0000, 32'h0,        0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dreg_bank.md
Name: dreg_bank

Overview:
- Parametrised multi-channel D-register bank; edge-triggered successor to the team's single-bit enable/reset storage element.
- Adds width and channel generalisation, a runtime mode select, and atomic snapshot capture with a valid/ready readout handshake.
- Sits between sampled status/data sources and a register-read or streaming consumer.
- Snapshot gives the consumer a coherent multi-channel view.

Parameters:
- WIDTH, 8, bits per channel (>=1)
- CHANNELS, 4, number of independent channels (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- mode  input  2  00 TRACK, 01 SNAPSHOT, 10 HOLD, 11 CLEAR; sampled every cycle
- en  input  CHANNELS  per-channel load enable
- d  input  CHANNELS*WIDTH  channel data; channel i = d[i*WIDTH +: WIDTH]
- capture  input  1  snapshot request strobe
- clr_overrun  input  1  clears sticky overrun
- q  output  CHANNELS*WIDTH  live registered channel values
- changed  output  CHANNELS  per-channel one-cycle pulse: q[i] changed value last edge
- snap_q  output  CHANNELS*WIDTH  snapshot data, stable while out_valid
- out_valid  output  1  snapshot pending
- out_ready  input  1  consumer accepts snapshot
- overrun  output  1  sticky: capture dropped because snapshot still pending

Behaviour:
- Reset (rst=1 at edge): q, snap_q, changed, out_valid and overrun all go to 0. Reset overrides every other input, including mid-handshake; a pending snapshot is discarded.
- Define nq[i] = (en[i] && mode in {TRACK, SNAPSHOT}) ? d[i] : q[i]. Registers load on the edge, so latency is 1 cycle.
- TRACK:
  - q <= nq.
  - capture is ignored.
- SNAPSHOT:
  - q <= nq.
  - If capture is accepted, snap_q <= nq (the post-update values of all channels, taken atomically), and out_valid is 1 from the next cycle.
- HOLD:
  - q is frozen and en is ignored.
  - capture is ignored.
  - The readout handshake still operates.
- CLEAR:
  - q, snap_q, out_valid and overrun go to 0 at the edge.
  - changed pulses for every channel whose q was nonzero.
- Readout FSM, two states:
  - EMPTY (out_valid=0):
    - capture in SNAPSHOT mode -> FULL.
  - FULL (out_valid=1):
    - out_ready=1 and no capture -> EMPTY.
    - out_ready=1 and capture: new snapshot loads and the state stays FULL (back-to-back, no bubble).
    - out_ready=0 and capture: the capture is dropped, snap_q is unchanged, and overrun <= 1.
- snap_q is guaranteed stable while out_valid=1 and out_ready=0.
- overrun:
  - Sticky; clears on clr_overrun or CLEAR mode.
  - If set and clear occur in the same cycle, set wins.
- changed[i] <= (next q[i] != q[i]).
  - Always registered, never combinational from d.
  - 0 in HOLD.
- Mode change takes effect on the edge where the new value is sampled. No FSM state is lost except in CLEAR.

Optional Feature:
- Macro DREG_BANK_PARITY_EN.
- When defined:
  - Each channel stores an even-parity bit alongside q and snap_q.
  - Additional output parity_err (CHANNELS wide, registered) asserts for one cycle when stored q[i] parity mismatches its recomputed value.
  - Parity bits reset to 0, which is consistent for data 0.
- When undefined:
  - No parity storage.
  - parity_err port is absent.
  - Area is minimal.

Decomposition:
- Package dreg_pkg holds:
  - mode enum: MODE_TRACK=2'b00, MODE_SNAPSHOT=2'b01, MODE_HOLD=2'b10, MODE_CLEAR=2'b11.
  - Readout FSM state enum: ST_EMPTY, ST_FULL.
- Sub-module dreg_channel (WIDTH):
  - One channel's q register, changed-pulse logic and optional parity.
  - Generated CHANNELS times.
- The snapshot register and FSM stay in the top level.

Test Plan:
- Reset/TRACK:
  - rst=1 for 2 cycles -> all outputs 0.
  - TRACK, en=4'b0101, d ch0=0x11, ch2=0x33 -> next cycle q ch0=0x11, ch2=0x33, others 0.
  - changed=4'b0101 for one cycle, then 0.
- HOLD:
  - q=0xAA on all channels; mode=HOLD, en=all 1, d=0x55 -> q stays 0xAA.
  - changed=0; capture ignored, out_valid stays 0.
- Snapshot handshake:
  - SNAPSHOT, en ch1, d ch1=0x7E, capture=1 -> next cycle out_valid=1, snap_q ch1=0x7E.
  - out_ready held 0 for 3 cycles -> snap_q stable.
  - out_ready=1 -> out_valid 0 next cycle.
- Overrun:
  - While FULL with out_ready=0, capture with new d=0x01 -> snap_q unchanged, overrun=1.
  - overrun persists after the drain.
  - clr_overrun=1 -> overrun=0.
  - clr_overrun and a new overrun in the same cycle -> overrun=1.
- Back-to-back and CLEAR:
  - FULL with out_ready=1 and capture=1 in the same cycle -> out_valid stays 1 and snap_q updates to the new values.
  - Then mode=CLEAR -> q, snap_q, out_valid, overrun all 0.
- Reset mid-operation and parity (DREG_BANK_PARITY_EN):
  - rst during FULL -> out_valid=0 next cycle.
  - Force-flip a stored q bit via backdoor -> parity_err[i]=1 for one cycle.
